// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   rx_state_e        : receiver FSM state encoding
//   CLKS_PER_BIT_DEF  : default system clocks per serial bit (100 MHz / 115200)
//   DATA_BITS_DEF     : default data bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, both flops load RESET_VAL
//   d_i   : asynchronous input
//   q_o   : synchronised output, two clocks behind d_i
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1 by default). Synchronises rx_i, detects the start edge,
// samples each bit at its centre and delivers bytes on a valid/ready port.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   rx_i        : asynchronous serial line, idle high
//   rx_data_o   : received byte, stable while rx_valid_o is high
//   rx_valid_o  : byte available, held until accepted
//   rx_ready_i  : consumer ready
//   frame_err_o : one-cycle pulse, stop bit sampled low
//   overrun_o   : one-cycle pulse, good byte dropped because the previous one
//                 was still pending
//   busy_o      : FSM is not in IDLE
//
// Handshake: a byte transfers on every rising edge where rx_valid_o and
// rx_ready_i are both high. rx_valid_o and rx_data_o do not change while a byte
// is pending and unaccepted; a byte completing in the same cycle as an
// acceptance replaces the old one and rx_valid_o stays high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q, rx_prev_d;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  always_comb begin
    rx_prev_d   = rx_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    // A pending byte is released by acceptance; a new byte may override below.
    valid_d     = valid_q & ~rx_ready_i;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge, not level: a line held low (break) cannot restart a frame.
        if (rx_prev_q && !rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d     = '0;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            if (!valid_q || rx_ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_i = 1'b1;
  logic          rx_ready_i = 1'b0;
  logic [DB-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          busy_o;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DB-1:0] exp_q[$];
  int valid_cycles = 0;
  int ferr_cycles  = 0;
  int ovr_cycles   = 0;
  int busy_cycles  = 0;
  int acc_cnt      = 0;
  logic          rst_at_edge = 1'b1;
  logic          prev_hold = 1'b0;
  logic [DB-1:0] prev_data = '0;

  always @(posedge clk) rst_at_edge = rst_i;

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      if (rx_valid_o)  valid_cycles++;
      if (frame_err_o) ferr_cycles++;
      if (overrun_o)   ovr_cycles++;
      if (busy_o)      busy_cycles++;
      // A pending unaccepted byte must stay put.
      if (prev_hold) begin
        check("hold_valid", {31'd0, rx_valid_o}, 32'd1);
        check("hold_data", {24'd0, rx_data_o}, {24'd0, prev_data});
      end
      if (rx_valid_o && rx_ready_i) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, rx_data_o}, 32'hFFFF_FFFF);
        end else begin
          check("accepted_byte", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    prev_hold = !rst_at_edge && rx_valid_o && !rx_ready_i && !rst_i;
    prev_data = rx_data_o;
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    idle(CPB);
  endtask

  // Leaves the line at the stop-bit level when it returns.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(data[i]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    logic          exp_byte;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[5];

  int s_valid, s_ferr, s_ovr, s_busy, s_acc;

  task automatic snap();
    s_valid = valid_cycles;
    s_ferr  = ferr_cycles;
    s_ovr   = ovr_cycles;
    s_busy  = busy_cycles;
    s_acc   = acc_cnt;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hC3, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 0};

    rst_i = 1'b1;
    idle(3);
    rst_i = 1'b0;
    check("reset_data",  {24'd0, rx_data_o}, 32'd0);
    check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
    check("reset_ferr",  {31'd0, frame_err_o}, 32'd0);
    check("reset_ovr",   {31'd0, overrun_o}, 32'd0);
    check("reset_busy",  {31'd0, busy_o}, 32'd0);
    idle(4);

    // Table-driven single frames with the consumer always ready.
    rx_ready_i = 1'b1;
    for (int v = 0; v < 5; v++) begin
      snap();
      if (vecs[v].exp_byte) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop);
      rx_i = 1'b1;
      idle(3 * CPB);
      check($sformatf("vec%0d_valid_cycles", v), valid_cycles - s_valid, {31'd0, vecs[v].exp_byte});
      check($sformatf("vec%0d_accepts", v), acc_cnt - s_acc, {31'd0, vecs[v].exp_byte});
      check($sformatf("vec%0d_ferr", v), ferr_cycles - s_ferr, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr_cycles - s_ovr, 32'd0);
      check($sformatf("vec%0d_idle", v), {30'd0, busy_o, rx_valid_o}, 32'd0);
    end

    // Bad stop bit, then a 40 bit-time break, then a normal frame.
    snap();
    send_frame(8'h3C, 1'b0);
    rx_i = 1'b0;
    idle(40 * CPB);
    rx_i = 1'b1;
    idle(4 * CPB);
    check("break_ferr", ferr_cycles - s_ferr, 32'd1);
    check("break_valid", valid_cycles - s_valid, 32'd0);
    check("break_ovr", ovr_cycles - s_ovr, 32'd0);
    check("break_busy", {31'd0, busy_o}, 32'd0);
    snap();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(3 * CPB);
    check("after_break_accepts", acc_cnt - s_acc, 32'd1);

    // Overrun: two frames with nobody accepting.
    rx_ready_i = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    idle(2 * CPB);
    send_frame(8'h22, 1'b1);
    idle(2 * CPB);
    check("ovr_valid", {31'd0, rx_valid_o}, 32'd1);
    check("ovr_data", {24'd0, rx_data_o}, 32'h11);
    check("ovr_pulse", ovr_cycles - s_ovr, 32'd1);
    check("ovr_ferr", ferr_cycles - s_ferr, 32'd0);
    exp_q.push_back(8'h11);
    rx_ready_i = 1'b1;
    idle(2);
    check("ovr_drain_valid", {31'd0, rx_valid_o}, 32'd0);
    check("ovr_drain_accepts", acc_cnt - s_acc, 32'd1);

    // 3-clock low glitch on an idle line.
    snap();
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(2 * CPB);
    check("glitch_busy_seen", {31'd0, (busy_cycles - s_busy) > 0}, 32'd1);
    check("glitch_busy_end", {31'd0, busy_o}, 32'd0);
    check("glitch_valid", valid_cycles - s_valid, 32'd0);
    check("glitch_ferr", ferr_cycles - s_ferr, 32'd0);

    // Acceptance in the exact cycle the second byte completes.
    rx_ready_i = 1'b0;
    send_frame(8'h55, 1'b1);
    idle(2 * CPB);
    check("pend_data", {24'd0, rx_data_o}, 32'h55);
    exp_q.push_back(8'h55);
    snap();
    fork
      send_frame(8'hAA, 1'b1);
      begin
        // Stop-bit sample edge is the 155th rising edge after the line falls.
        idle(154);
        rx_ready_i = 1'b1;
        idle(1);
        rx_ready_i = 1'b0;
      end
    join
    idle(CPB);
    check("swap_valid", {31'd0, rx_valid_o}, 32'd1);
    check("swap_data", {24'd0, rx_data_o}, 32'hAA);
    check("swap_ovr", ovr_cycles - s_ovr, 32'd0);
    check("swap_accepts", acc_cnt - s_acc, 32'd1);

    // Reset in the middle of the data bits, with 0xAA still pending.
    snap();
    fork
      send_frame(8'hF0, 1'b1);
      begin
        idle(100);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        check("rst_mid_data", {24'd0, rx_data_o}, 32'd0);
        check("rst_mid_flags", {28'd0, rx_valid_o, frame_err_o, overrun_o, busy_o}, 32'd0);
      end
    join
    idle(2 * CPB);
    check("rst_after_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_after_busy", {31'd0, busy_o}, 32'd0);
    check("rst_after_ferr", ferr_cycles - s_ferr, 32'd0);
    rx_ready_i = 1'b1;
    snap();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(3 * CPB);
    check("post_rst_accepts", acc_cnt - s_acc, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
